// File: rtl/barrel_distortion_correction.sv
// Frame-store radial lens-distortion corrector: loads one AXI4-Stream frame, then emits it inverse-mapped.
// Optional macro BDC_EDGE_CLAMP_EN: clamp out-of-range source coordinates to the frame edge instead of outputting black.
module barrel_distortion_correction #(
    parameter int          WIDTH         = 128,
    parameter int          HEIGHT        = 100,
    parameter int          DATA_WIDTH    = 24,
    parameter logic [15:0] DISTORTION_K1 = 16'h0000,
    parameter int          BUFFER_LINES  = HEIGHT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int AW    = $clog2(NPIX);
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int CX    = WIDTH / 2;
    localparam int CY    = HEIGHT / 2;
    localparam int R2MAX = CX * CX + CY * CY;
    localparam int INV   = (1 << 24) / R2MAX;
    localparam logic signed [31:0] K1_EXT = {{16{DISTORTION_K1[15]}}, DISTORTION_K1};

    generate
        if (BUFFER_LINES != HEIGHT) begin : g_bad_buffer_lines
            $error("barrel_distortion_correction: BUFFER_LINES must equal HEIGHT");
        end
    endgenerate

    typedef enum logic {ST_LOAD, ST_PROCESS} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            gen_done_q, gen_done_d;
    logic            gen_valid;
    logic            in_fire;
    logic            pipe_en;
    logic            unused_tlast;

    logic [DATA_WIDTH-1:0] mem [NPIX];
    logic [DATA_WIDTH-1:0] rd_q;

    // Stage registers: 1 = radius, 2 = source address, 3 = memory read, 4 = output.
    logic               v1_q, first1_q, last1_q;
    logic signed [31:0] dx1_q, dy1_q, r2q1_q;
    logic               v2_q, first2_q, last2_q, inr2_q;
    logic [AW-1:0]      addr2_q;
    logic               v3_q, first3_q, last3_q, inr3_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic               m_tvalid_q, m_tlast_q, m_tuser_q;

    logic signed [31:0] dx_d, dy_d, r2_d, r2q_d;
    logic signed [31:0] kr_d, scale_d, sx_d, sy_d;
    logic               inr_d;
    logic [AW-1:0]      addr_d;

    assign unused_tlast  = s_axis_tlast;
    assign s_axis_tready = (state_q == ST_LOAD) && !rst;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign pipe_en       = !m_tvalid_q || m_axis_tready;
    assign gen_valid     = (state_q == ST_PROCESS) && !gen_done_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        x_d        = x_q;
        y_d        = y_q;
        gen_done_d = gen_done_q;
        case (state_q)
            ST_LOAD: begin
                x_d        = '0;
                y_d        = '0;
                gen_done_d = 1'b0;
                if (in_fire) begin
                    if (s_axis_tuser) begin
                        wr_ptr_d = AW'(1);
                    end else if (wr_ptr_q == AW'(NPIX - 1)) begin
                        wr_ptr_d = '0;
                        state_d  = ST_PROCESS;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            ST_PROCESS: begin
                if (gen_valid && pipe_en) begin
                    if (x_q == XW'(WIDTH - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(HEIGHT - 1)) gen_done_d = 1'b1;
                        else                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
                if (m_tvalid_q && m_axis_tready && m_tlast_q) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            wr_ptr_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            gen_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            gen_done_q <= gen_done_d;
        end
    end

    always_comb begin
        dx_d  = $signed(32'(x_q)) - CX;
        dy_d  = $signed(32'(y_q)) - CY;
        r2_d  = dx_d * dx_d + dy_d * dy_d;
        r2q_d = (r2_d * INV) >>> 12;
    end

    // Arithmetic shifts floor toward minus infinity, so negative offsets round outward.
    always_comb begin
        kr_d    = K1_EXT * r2q1_q;
        scale_d = 32'sd4096 + (kr_d >>> 12);
        sx_d    = CX + ((dx1_q * scale_d) >>> 12);
        sy_d    = CY + ((dy1_q * scale_d) >>> 12);
`ifdef BDC_EDGE_CLAMP_EN
        if (sx_d < 0)               sx_d = 0;
        else if (sx_d > WIDTH - 1)  sx_d = WIDTH - 1;
        if (sy_d < 0)               sy_d = 0;
        else if (sy_d > HEIGHT - 1) sy_d = HEIGHT - 1;
        inr_d = 1'b1;
`else
        inr_d = (sx_d >= 0) && (sx_d < WIDTH) && (sy_d >= 0) && (sy_d < HEIGHT);
`endif
        addr_d = inr_d ? AW'(sy_d * WIDTH + sx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem[s_axis_tuser ? '0 : wr_ptr_q] <= s_axis_tdata;
        if (pipe_en) rd_q <= mem[addr2_q];
    end

    // A single enable freezes every stage, so a stalled output beat cannot change or be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            first1_q   <= 1'b0;
            last1_q    <= 1'b0;
            dx1_q      <= '0;
            dy1_q      <= '0;
            r2q1_q     <= '0;
            v2_q       <= 1'b0;
            first2_q   <= 1'b0;
            last2_q    <= 1'b0;
            inr2_q     <= 1'b0;
            addr2_q    <= '0;
            v3_q       <= 1'b0;
            first3_q   <= 1'b0;
            last3_q    <= 1'b0;
            inr3_q     <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
        end else if (pipe_en) begin
            v1_q       <= gen_valid;
            first1_q   <= (x_q == '0) && (y_q == '0);
            last1_q    <= (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
            dx1_q      <= dx_d;
            dy1_q      <= dy_d;
            r2q1_q     <= r2q_d;
            v2_q       <= v1_q;
            first2_q   <= first1_q;
            last2_q    <= last1_q;
            inr2_q     <= inr_d;
            addr2_q    <= addr_d;
            v3_q       <= v2_q;
            first3_q   <= first2_q;
            last3_q    <= last2_q;
            inr3_q     <= inr2_q;
            m_tdata_q  <= inr3_q ? rd_q : '0;
            m_tvalid_q <= v3_q;
            m_tlast_q  <= v3_q && last3_q;
            m_tuser_q  <= v3_q && first3_q;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tuser  = m_tuser_q;

endmodule

// File: tb/tb_barrel_distortion_correction.sv
// Bench for barrel_distortion_correction: three instances (K1 = 0, -2.0, +1.0) on a 16x12 frame share one stream.
module tb_barrel_distortion_correction;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int N  = W * H;
    localparam int DW = 24;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0]          s_data;
    logic                   s_valid, s_last, s_user;
    logic [NI-1:0]          s_ready, m_valid, m_last, m_user;
    logic [NI-1:0][DW-1:0]  m_data;
    logic                   m_ready;

    function automatic logic [15:0] k1_of(int i);
        case (i)
            0:       return 16'h0000;
            1:       return 16'hE000;
            default: return 16'h1000;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            barrel_distortion_correction #(
                .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW),
                .DISTORTION_K1(k1_of(gi)), .BUFFER_LINES(H)
            ) u_dut (
                .clk(clk), .rst(rst),
                .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
                .s_axis_tlast(s_last), .s_axis_tuser(s_user),
                .s_axis_tready(s_ready[gi]),
                .m_axis_tdata(m_data[gi]), .m_axis_tvalid(m_valid[gi]),
                .m_axis_tlast(m_last[gi]), .m_axis_tuser(m_user[gi]),
                .m_axis_tready(m_ready)
            );
        end
    endgenerate

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] src [N];
    logic [DW-1:0] cap_data [NI][N];
    logic          cap_user [NI][N];
    logic          cap_last [NI][N];
    int            cap_cnt  [NI];
    int            extra_cnt;
    bit            mon_en = 1'b0;
    bit            prev_stall [NI];
    logic [DW+1:0] prev_word  [NI];
    int            rmode = 0;

    typedef struct {
        int            inst;
        int            x;
        int            y;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [9];

    task automatic check(string name, int inst, int idx, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d idx%0d: got %h expected %h", name, inst, idx, act, exp);
        end
    endtask

    function automatic int fdiv(int a, int b);
        int q = a / b;
        if ((a % b) != 0 && a < 0) q -= 1;
        return q;
    endfunction

    // Reference: inverse radial mapping evaluated with plain integer arithmetic on the stored frame.
    function automatic logic [DW-1:0] model_pix(int k, int p);
        int x = p % W;
        int y = p / W;
        int cx = W / 2;
        int cy = H / 2;
        int dx = x - cx;
        int dy = y - cy;
        int inv = (1 << 24) / (cx * cx + cy * cy);
        int r2q = ((dx * dx + dy * dy) * inv) / 4096;
        int k1 = $signed(k1_of(k));
        int scale = 4096 + fdiv(k1 * r2q, 4096);
        int sx = cx + fdiv(dx * scale, 4096);
        int sy = cy + fdiv(dy * scale, 4096);
`ifdef BDC_EDGE_CLAMP_EN
        sx = (sx < 0) ? 0 : ((sx > W - 1) ? W - 1 : sx);
        sy = (sy < 0) ? 0 : ((sy > H - 1) ? H - 1 : sy);
`endif
        if (sx < 0 || sx >= W || sy < 0 || sy >= H) return '0;
        return src[sy * W + sx];
    endfunction

    // Output monitor: records accepted beats and checks that stalled beats hold still.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst || !mon_en) begin
                    prev_stall[i] = 1'b0;
                end else begin
                    if (prev_stall[i]) begin
                        n_vec++;
                        if (!m_valid[i] || {m_data[i], m_user[i], m_last[i]} !== prev_word[i]) begin
                            n_err++;
                            $display("FAIL stall_hold inst%0d: got v=%b word=%h expected v=1 word=%h",
                                     i, m_valid[i], {m_data[i], m_user[i], m_last[i]}, prev_word[i]);
                        end
                    end
                    prev_stall[i] = m_valid[i] && !m_ready;
                    prev_word[i]  = {m_data[i], m_user[i], m_last[i]};
                    if (m_valid[i] && m_ready) begin
                        if (cap_cnt[i] < N) begin
                            cap_data[i][cap_cnt[i]] = m_data[i];
                            cap_user[i][cap_cnt[i]] = m_user[i];
                            cap_last[i][cap_cnt[i]] = m_last[i];
                        end else begin
                            extra_cnt++;
                        end
                        cap_cnt[i]++;
                    end
                end
            end
        end
    end

    // Downstream ready: always high, toggling then 30% random low, or 30% random low.
    initial begin
        int rcyc = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (rcyc < 400) ? rcyc[0] : ($urandom_range(0, 99) >= 30);
                default: m_ready = ($urandom_range(0, 99) >= 30);
            endcase
        end
    end

    task automatic clear_caps();
        for (int i = 0; i < NI; i++) begin
            cap_cnt[i]    = 0;
            prev_stall[i] = 1'b0;
        end
        extra_cnt = 0;
    endtask

    task automatic send_beats(int count, bit from_src);
        for (int i = 0; i < count; i++) begin
            int b = 0;
            while ($urandom_range(0, 9) < 2) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = from_src ? src[i] : DW'($urandom);
            s_user  = (i == 0);
            s_last  = (i == count - 1);
            while (!s_ready[0]) begin
                @(posedge clk);
                #1;
                b++;
                if (b > 200) begin
                    $display("FAIL s_axis_tready timeout: got 0 expected 1");
                    $fatal(1, "input stalled");
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_user  = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_frame(string tag);
        int b = 0;
        while (!(cap_cnt[0] >= N && cap_cnt[1] >= N && cap_cnt[2] >= N) && b < 5000) begin
            @(posedge clk);
            b++;
        end
        check("frame_timeout", 0, b, (b < 5000) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("extra_beats", 0, 0, extra_cnt, 0);
        check("idle_tvalid", 0, 0, 32'(m_valid), 0);
        check("idle_tready", 0, 0, 32'(s_ready), 32'(3'b111));
        $display("frame %s: captured %0d/%0d/%0d beats", tag, cap_cnt[0], cap_cnt[1], cap_cnt[2]);
    endtask

    task automatic check_frame();
        for (int i = 0; i < NI; i++) begin
            check("beat_count", i, 0, cap_cnt[i], N);
            for (int p = 0; p < N; p++) begin
                check("pixel", i, p, 32'(cap_data[i][p]), 32'(model_pix(i, p)));
                check("tuser", i, p, 32'(cap_user[i][p]), (p == 0) ? 1 : 0);
                check("tlast", i, p, 32'(cap_last[i][p]), (p == N - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic random_src();
        for (int p = 0; p < N; p++) src[p] = DW'($urandom);
    endtask

    initial begin
        int lat;
        int b;
        logic [DW-1:0] corner_k2;
`ifdef BDC_EDGE_CLAMP_EN
        corner_k2 = 24'h800000;
`else
        corner_k2 = 24'h000000;
`endif
        // Hand-derived points on the marked ramp frame (pixel i = 0x800000 + i).
        tbl[0] = '{0,  0,  0, 24'h800000};
        tbl[1] = '{0, 15, 11, 24'h8000BF};
        tbl[2] = '{0,  5,  3, 24'h800035};
        tbl[3] = '{1,  8,  6, 24'h800068};
        tbl[4] = '{1,  0,  0, 24'h8000BF};
        tbl[5] = '{1, 15, 11, 24'h800034};
        tbl[6] = '{2,  8,  6, 24'h800068};
        tbl[7] = '{2,  0,  0, corner_k2};
`ifdef BDC_EDGE_CLAMP_EN
        tbl[8] = '{2, 15, 11, 24'h8000BF};
`else
        tbl[8] = '{2, 15, 11, 24'h000000};
`endif

        rst = 1'b1;
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0; s_data = '0;
        #1;
        check("reset_s_tready", 0, 0, 32'(s_ready), 0);
        check("reset_m_tvalid", 0, 0, 32'(m_valid), 0);
        check("reset_m_tdata", 0, 0, 32'(m_data[0] | m_data[1] | m_data[2]), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_s_tready", 0, 0, 32'(s_ready), 32'(3'b111));
        check("post_reset_m_tvalid", 0, 0, 32'(m_valid), 0);

        // Ramp frame, downstream always ready.
        for (int p = 0; p < N; p++) src[p] = 24'h800000 + DW'(p);
        rmode = 0;
        clear_caps();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send_beats(N, 1'b1);
        lat = 0;
        while (!m_valid[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_valid_within_8", 0, lat, (lat <= 8) ? 1 : 0, 1);
        wait_frame("ramp");
        check_frame();
        for (int v = 0; v < 9; v++)
            check("table_point", tbl[v].inst, tbl[v].y * W + tbl[v].x,
                  32'(cap_data[tbl[v].inst][tbl[v].y * W + tbl[v].x]), 32'(tbl[v].exp));

        // Random frame under toggling then random backpressure.
        random_src();
        rmode = 1;
        clear_caps();
        send_beats(N, 1'b1);
        wait_frame("backpressure");
        check_frame();

        // Load restarted by tuser after 50 junk beats.
        random_src();
        rmode = 2;
        clear_caps();
        send_beats(50, 1'b0);
        send_beats(N, 1'b1);
        wait_frame("tuser_restart");
        check_frame();

        // Reset pulsed while emitting, then a fresh frame.
        random_src();
        rmode = 0;
        clear_caps();
        send_beats(N, 1'b1);
        b = 0;
        while (cap_cnt[0] < 20 && b < 1000) begin
            @(posedge clk);
            b++;
        end
        check("reached_process", 0, b, (b < 1000) ? 1 : 0, 1);
        #2;
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        check("midframe_reset_m_tvalid", 0, 0, 32'(m_valid), 0);
        check("midframe_reset_m_tdata", 0, 0, 32'(m_data[0] | m_data[1] | m_data[2]), 0);
        check("midframe_reset_s_tready", 0, 0, 32'(s_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_caps();
        mon_en = 1'b1;
        random_src();
        rmode = 2;
        send_beats(N, 1'b1);
        wait_frame("after_reset");
        check_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
